// File: rtl/vram_arbiter.sv
// Video RAM arbiter: video fetches take the RAM with zero latency, and CPU accesses
// run in the ce ticks that video leaves free. An access that video interrupts is retried.
module vram_arbiter #(
  parameter int AW        = 13,
  parameter int DW        = 8,
  parameter int ACC_TICKS = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic          vreq,
  input  logic [1:0]    vid_b,
  input  logic [AW-1:0] vid_a,
  output logic [DW-1:0] vid_q,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW+1:0] cpu_a,
  input  logic [DW-1:0] cpu_d,
  output logic [DW-1:0] cpu_q,
  output logic          cpu_ack,
  output logic          cpu_wait,
  output logic [AW+1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic          mem_we,
  input  logic [DW-1:0] mem_q
);

  localparam int CW = $clog2(ACC_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CPU_A = 2'd1,
    CPU_D = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [AW+1:0] a_l;
  logic [DW-1:0] d_l;
  logic          wr_l;
  logic          complete;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    complete = 1'b0;
    case (state)
      IDLE:  if (cpu_req) state_nx = CPU_A;
      CPU_A: if (!vreq) begin
               state_nx = CPU_D;
               cnt_nx   = CW'(1);
             end
      CPU_D: if (vreq) begin
               state_nx = CPU_A;
               cnt_nx   = '0;
             end else if (cnt == CW'(ACC_TICKS)) begin
               complete = 1'b1;
               state_nx = DONE;
             end else begin
               cnt_nx = cnt + CW'(1);
             end
      // Holding here until the request drops keeps a slow CPU from getting a second access.
      DONE:  if (!cpu_req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // The ack is cleared on every clock, so it is one clock wide even when ce is sparse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      a_l     <= '0;
      d_l     <= '0;
      wr_l    <= 1'b0;
      cpu_q   <= '0;
      cpu_ack <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      if (ce) begin
        state <= state_nx;
        cnt   <= cnt_nx;
        if (state == IDLE && cpu_req) begin
          a_l  <= cpu_a;
          d_l  <= cpu_d;
          wr_l <= cpu_wr;
        end
        if (complete) begin
          cpu_ack <= 1'b1;
          if (!wr_l) cpu_q <= mem_q;
        end
      end
    end
  end

  // Gating with reset drops the write strobe in the same clock that reset is sampled.
  assign mem_a    = vreq ? {vid_b, vid_a} : a_l;
  assign mem_d    = d_l;
  assign mem_we   = (state == CPU_D) && wr_l && !vreq && !reset;
  assign vid_q    = mem_q;
  assign cpu_wait = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: one instance with ACC_TICKS=2 and one with ACC_TICKS=1,
// each connected to its own byte-wide RAM model.
module tb_vram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        ce;

  logic        vreq, cpu_req, cpu_wr, cpu_ack, cpu_wait, mem_we;
  logic [1:0]  vid_b;
  logic [12:0] vid_a;
  logic [14:0] cpu_a, mem_a;
  logic [7:0]  vid_q, cpu_d, cpu_q, mem_d, mem_q;

  logic        vreq_1, cpu_req_1, cpu_wr_1, cpu_ack_1, cpu_wait_1, mem_we_1;
  logic [1:0]  vid_b_1;
  logic [12:0] vid_a_1;
  logic [14:0] cpu_a_1, mem_a_1;
  logic [7:0]  vid_q_1, cpu_d_1, cpu_q_1, mem_d_1, mem_q_1;

  logic [7:0]  ram   [0:32767];
  logic [7:0]  ram_1 [0:32767];
  logic        pl_we, pl_we_1;
  logic [14:0] pl_a;
  logic [7:0]  pl_d;

  int n_checks = 0;
  int n_fail   = 0;
  int ack_cnt  = 0;
  int ack_cnt_1 = 0;
  int we_cnt   = 0;

  vram_arbiter #(.AW(13), .DW(8), .ACC_TICKS(2)) dut (
    .clock(clock), .reset(reset), .ce(ce), .vreq(vreq), .vid_b(vid_b), .vid_a(vid_a),
    .vid_q(vid_q), .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_d(cpu_d),
    .cpu_q(cpu_q), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait), .mem_a(mem_a), .mem_d(mem_d),
    .mem_we(mem_we), .mem_q(mem_q)
  );

  vram_arbiter #(.AW(13), .DW(8), .ACC_TICKS(1)) dut_1 (
    .clock(clock), .reset(reset), .ce(ce), .vreq(vreq_1), .vid_b(vid_b_1), .vid_a(vid_a_1),
    .vid_q(vid_q_1), .cpu_req(cpu_req_1), .cpu_wr(cpu_wr_1), .cpu_a(cpu_a_1), .cpu_d(cpu_d_1),
    .cpu_q(cpu_q_1), .cpu_ack(cpu_ack_1), .cpu_wait(cpu_wait_1), .mem_a(mem_a_1),
    .mem_d(mem_d_1), .mem_we(mem_we_1), .mem_q(mem_q_1)
  );

  always #5 clock = ~clock;

  // Asynchronous-read RAM models with a bench-side preload port.
  assign mem_q   = ram[mem_a];
  assign mem_q_1 = ram_1[mem_a_1];

  always @(posedge clock) begin
    if (mem_we) ram[mem_a] <= mem_d;
    if (pl_we)  ram[pl_a]  <= pl_d;
  end

  always @(posedge clock) begin
    if (mem_we_1) ram_1[mem_a_1] <= mem_d_1;
    if (pl_we_1)  ram_1[pl_a]    <= pl_d;
  end

  always @(negedge clock) begin
    if (cpu_ack === 1'b1)   ack_cnt   <= ack_cnt + 1;
    if (cpu_ack_1 === 1'b1) ack_cnt_1 <= ack_cnt_1 + 1;
    if (mem_we === 1'b1)    we_cnt    <= we_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input int inst, input logic [14:0] a, input logic [7:0] d);
    pl_a = a;
    pl_d = d;
    if (inst == 0) pl_we = 1'b1; else pl_we_1 = 1'b1;
    tick();
    pl_we   = 1'b0;
    pl_we_1 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ce    = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (cpu_ack !== 1'b0 || cpu_q !== 8'h00 || mem_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: ack=%b q=%h we=%b required ack=0 q=00 we=0",
               cpu_ack, cpu_q, mem_we);
    end
    n_checks++;
    if (dut.state !== 2'd0 || dut_1.state !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got %0d/%0d required 0/0", dut.state, dut_1.state);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (mem_we !== 1'b0 || mem_a !== 15'h0000) begin
      n_fail++;
      $display("[TB] FAIL after_reset: we=%b a=%h required we=0 a=0000", mem_we, mem_a);
    end
  endtask

  task automatic test_read();
    int base;
    base    = ack_cnt;
    cpu_req = 1'b1;
    cpu_wr  = 1'b0;
    cpu_a   = 15'h2345;
    #1;
    n_checks++;
    if (cpu_wait !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL read_wait: got %b required 1", cpu_wait);
    end
    tick();
    n_checks++;
    if (mem_a !== 15'h2345) begin
      n_fail++;
      $display("[TB] FAIL read_addr: got %h required 2345", mem_a);
    end
    // Counting the request edge as the first, the ack is seen at the fourth edge.
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++;
      if (cpu_ack !== (k == 3)) begin
        n_fail++;
        $display("[TB] FAIL read_ack_timing: edge %0d ack=%b required %b", k, cpu_ack, k == 3);
      end
    end
    n_checks++;
    if (cpu_q !== 8'hA5 || cpu_wait !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL read_data: q=%h wait=%b required q=A5 wait=0", cpu_q, cpu_wait);
    end
    cpu_req = 1'b0;
    tick();
    n_checks++;
    if (cpu_ack !== 1'b0 || ack_cnt - base !== 1) begin
      n_fail++;
      $display("[TB] FAIL read_ack_pulse: ack=%b acks=%0d required ack=0 acks=1",
               cpu_ack, ack_cnt - base);
    end
  endtask

  task automatic test_write_abort();
    int  base;
    bit  got;
    base    = ack_cnt;
    cpu_req = 1'b1;
    cpu_wr  = 1'b1;
    cpu_a   = 15'h0100;
    cpu_d   = 8'h5A;
    tick();
    tick();
    vreq  = 1'b1;
    vid_b = 2'b11;
    vid_a = 13'h1FFF;
    #1;
    n_checks++;
    if (mem_we !== 1'b0 || mem_a !== 15'h7FFF || vid_q !== 8'h77) begin
      n_fail++;
      $display("[TB] FAIL abort_mux: we=%b a=%h vq=%h required we=0 a=7FFF vq=77",
               mem_we, mem_a, vid_q);
    end
    tick();
    vreq = 1'b0;
    got  = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (cpu_ack === 1'b1) got = 1'b1;
    end
    cpu_req = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (!got || ack_cnt - base !== 1) begin
      n_fail++;
      $display("[TB] FAIL abort_ack: seen=%b acks=%0d required seen=1 acks=1",
               got, ack_cnt - base);
    end
    n_checks++;
    if (ram[15'h0100] !== 8'h5A || ram[15'h7FFF] !== 8'h77) begin
      n_fail++;
      $display("[TB] FAIL abort_ram: [0100]=%h [7FFF]=%h required 5A/77",
               ram[15'h0100], ram[15'h7FFF]);
    end
  endtask

  task automatic test_alternating();
    int  base;
    bit  got;
    bit  vid_ok;
    logic [7:0] exp_v;
    base      = ack_cnt_1;
    got       = 1'b0;
    vid_ok    = 1'b1;
    cpu_req_1 = 1'b1;
    cpu_wr_1  = 1'b0;
    cpu_a_1   = 15'h1234;
    for (int k = 0; k < 8; k++) begin
      vreq_1  = (k % 2 == 0);
      vid_b_1 = 2'b01;
      vid_a_1 = 13'(k);
      exp_v   = 8'h40 + 8'(k);
      #1;
      if (vreq_1 && (vid_q_1 !== exp_v || mem_we_1 !== 1'b0)) vid_ok = 1'b0;
      tick();
      if (cpu_ack_1 === 1'b1) got = 1'b1;
    end
    n_checks++;
    if (!vid_ok) begin
      n_fail++;
      $display("[TB] FAIL alt_video: video data or we wrong, got ok=0 required ok=1");
    end
    vreq_1 = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (cpu_ack_1 === 1'b1) got = 1'b1;
    end
    cpu_req_1 = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (!got || cpu_q_1 !== 8'h3C || ack_cnt_1 - base !== 1) begin
      n_fail++;
      $display("[TB] FAIL alt_read: seen=%b q=%h acks=%0d required seen=1 q=3C acks=1",
               got, cpu_q_1, ack_cnt_1 - base);
    end
  endtask

  task automatic test_back_to_back();
    int  base, we_base;
    bit  got;
    base    = ack_cnt;
    we_base = we_cnt;
    cpu_req = 1'b1;
    cpu_wr  = 1'b1;
    cpu_a   = 15'h0200;
    cpu_d   = 8'hC3;
    got     = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (cpu_ack === 1'b1) got = 1'b1;
    end
    repeat (10) tick();
    n_checks++;
    if (!got || ack_cnt - base !== 1 || we_cnt - we_base !== 2) begin
      n_fail++;
      $display("[TB] FAIL held_req: seen=%b acks=%0d we_clocks=%0d required 1/1/2",
               got, ack_cnt - base, we_cnt - we_base);
    end
    n_checks++;
    if (ram[15'h0200] !== 8'hC3) begin
      n_fail++;
      $display("[TB] FAIL held_ram: got %h required C3", ram[15'h0200]);
    end
    cpu_req = 1'b0;
    tick();
    cpu_req = 1'b1;
    cpu_wr  = 1'b0;
    got     = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (cpu_ack === 1'b1) got = 1'b1;
    end
    cpu_req = 1'b0;
    tick();
    n_checks++;
    if (!got || cpu_q !== 8'hC3 || ack_cnt - base !== 2) begin
      n_fail++;
      $display("[TB] FAIL second_access: seen=%b q=%h acks=%0d required 1/C3/2",
               got, cpu_q, ack_cnt - base);
    end
  endtask

  task automatic test_reset_mid();
    int  base;
    bit  got;
    base    = ack_cnt;
    cpu_req = 1'b1;
    cpu_wr  = 1'b1;
    cpu_a   = 15'h0300;
    cpu_d   = 8'hE7;
    tick();
    tick();
    n_checks++;
    if (mem_we !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_we_before: got %b required 1", mem_we);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (mem_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_we_reset: got %b required 0", mem_we);
    end
    tick();
    cpu_req = 1'b0;
    reset   = 1'b0;
    n_checks++;
    if (dut.state !== 2'd0 || cpu_ack !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_idle: state=%0d ack=%b we=%b required 0/0/0",
               dut.state, cpu_ack, mem_we);
    end
    repeat (3) tick();
    n_checks++;
    if (ack_cnt !== base || ram[15'h0300] !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL mid_no_ack: acks=%0d ram=%h required %0d/00",
               ack_cnt, ram[15'h0300], base);
    end
    cpu_req = 1'b1;
    cpu_wr  = 1'b0;
    cpu_a   = 15'h2345;
    got     = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (cpu_ack === 1'b1) got = 1'b1;
    end
    cpu_req = 1'b0;
    tick();
    n_checks++;
    if (!got || cpu_q !== 8'hA5) begin
      n_fail++;
      $display("[TB] FAIL mid_recover: seen=%b q=%h required 1/A5", got, cpu_q);
    end
  endtask

  task automatic test_ce_hold();
    int hi_clocks;
    hi_clocks = 0;
    cpu_req   = 1'b1;
    cpu_wr    = 1'b0;
    cpu_a     = 15'h0200;
    for (int k = 0; k < 24; k++) begin
      ce = (k % 2 == 0);
      tick();
      if (cpu_ack === 1'b1) begin
        hi_clocks++;
        cpu_req = 1'b0;
      end
    end
    ce = 1'b1;
    tick();
    n_checks++;
    if (hi_clocks !== 1 || cpu_q !== 8'hC3) begin
      n_fail++;
      $display("[TB] FAIL ce_hold: ack_clocks=%0d q=%h required 1/C3", hi_clocks, cpu_q);
    end
  endtask

  initial begin
    reset = 1'b1;  ce = 1'b1;
    vreq = 1'b0;   vid_b = '0;   vid_a = '0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_a = '0; cpu_d = '0;
    vreq_1 = 1'b0; vid_b_1 = '0; vid_a_1 = '0;
    cpu_req_1 = 1'b0; cpu_wr_1 = 1'b0; cpu_a_1 = '0; cpu_d_1 = '0;
    pl_we = 1'b0;  pl_we_1 = 1'b0; pl_a = '0; pl_d = '0;

    test_reset();
    preload(0, 15'h2345, 8'hA5);
    preload(0, 15'h0100, 8'h11);
    preload(0, 15'h7FFF, 8'h77);
    preload(0, 15'h0300, 8'h00);
    preload(1, 15'h1234, 8'h3C);
    for (int k = 0; k < 8; k++) preload(1, 15'h2000 + 15'(k), 8'h40 + 8'(k));

    test_read();
    test_write_abort();
    test_alternating();
    test_back_to_back();
    test_reset_mid();
    test_ce_hold();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
